dino_game_ctrl: RTL and testbench
=================================

Name: dino_game_ctrl

Overview:
- Game-logic stage for the dinosaur game. Sits directly downstream of the clock divider.
- Consumes the divider's slow square wave `clock_out` as a game-tick level and edge-detects it in the `clock_in` domain.
- Runs the dinosaur jump state machine, the obstacle scroller, collision detection and the score counter.
- Feeds the display/render stage with dinosaur height, obstacle column, score and status flags.

Parameters:
- COLS, 16, number of playfield columns; obstacle enters at COLS-1 and wraps after column 0. Must be ≤16.
- DINO_COL, 2, fixed column occupied by the dinosaur. Must be < COLS.
- JUMP_H, 3, peak dinosaur height in rows. Must be 1..3.
- HANG_TICKS, 2, ticks spent at peak height. May be 0.
- SCORE_MAX, 9999, score saturation value.

Ports:
- clock_in  input  1  system clock; same clock as the divider.
- reset  input  1  synchronous, active-high reset.
- game_tick  input  1  divider `clock_out` level, synchronous to clock_in. Each rising edge is one game tick.
- btn_jump  input  1  raw jump pushbutton, asynchronous, active-high.
- dino_h  output  2  dinosaur height; 0 = on ground.
- obstacle_col  output  4  current obstacle column.
- score  output  14  obstacles passed, binary.
- running  output  1  high while in RUN.
- game_over  output  1  high while in OVER.

Behaviour:
- All ports and state registers are sampled on the posedge of clock_in.
- Reset (synchronous, active-high) has priority over everything else, including mid-jump and mid-tick. Reset values:
  - state = IDLE, jump = GROUND
  - dino_h = 0, obstacle_col = COLS-1, score = 0
  - running = 0, game_over = 0, jump_pending = 0
  - tick_q = 0, synchroniser flops = 0
- Tick detect: tick_q <= game_tick; tick_p = game_tick & ~tick_q. This is a one-cycle pulse per rising edge.
- Button path:
  - 2-flop synchroniser, then edge detect; press_p is a one-cycle pulse on each 0→1 transition.
  - Holding the button produces no further pulses.
- Top FSM:
  - IDLE: outputs held at reset values; ticks are ignored. press_p → RUN, and that press is consumed (no jump).
  - RUN: running = 1. Advances on every tick_p. Collision → OVER.
  - OVER: game_over = 1, running = 0. All positions and score are frozen; ticks are ignored. press_p → RUN with dino_h = 0, obstacle_col = COLS-1, score = 0, jump = GROUND, jump_pending = 0. That press is consumed.
- jump_pending (RUN only):
  - Set by press_p when jump = GROUND.
  - press_p while jump ≠ GROUND is ignored.
  - A press_p in the same cycle as tick_p is not seen by that tick; it sets jump_pending and is serviced on the next tick.
  - Cleared when the jump starts.
- On each tick_p in RUN:
  - Obstacle: obstacle_col decrements by 1. At 0 it wraps to COLS-1 and score increments by 1, saturating at SCORE_MAX.
  - Jump sub-FSM (one step per tick):
    - GROUND: if jump_pending → UP with dino_h = 1; otherwise stays.
    - UP: dino_h += 1. On reaching JUMP_H → HANG, counter loaded with HANG_TICKS (→ DOWN directly if HANG_TICKS = 0).
    - HANG: dino_h held. Counter decrements per tick; at expiry → DOWN.
    - DOWN: dino_h -= 1. On reaching 0 → GROUND.
  - With JUMP_H = 1, the UP step lands directly at peak.
- Collision:
  - Checked every clock cycle in RUN on the registered values: obstacle_col == DINO_COL && dino_h == 0.
  - When true, the state becomes OVER and game_over asserts on the next clock edge (one-cycle latency after the tick that caused it).
  - A tick_p arriving in the same cycle as a true collision check is ignored.
- Between ticks all outputs are stable. Outputs are registered with no combinational path from inputs.

Test Plan:
- Reset/idle: assert reset 2 cycles, then drive 20 ticks with no press → dino_h = 0, obstacle_col = 15, score = 0, running = 0, game_over = 0 throughout.
- Collision: press (start), no jump; after 13 ticks obstacle_col = 2 → game_over = 1 on the next cycle, running = 0. 5 more ticks → obstacle_col stays 2, score stays 0.
- Clear jump: start, press while obstacle_col = 4 → successive ticks give (col, h) = (3,1), (2,2), (1,3), (0,3), (15,3) with score = 1, then (14,2), (13,1), (12,0). No game_over.
- Press rules:
  - Press at h = 2 → no second jump after landing.
  - Press on the same cycle as tick_p → h stays 0 on that tick and becomes 1 on the following tick.
  - Held button → exactly one jump.
- Reset mid-jump: at h = 2, score = 1, assert reset → next cycle h = 0, obstacle_col = 15, score = 0, running = 0. The state is IDLE and ticks do not move the obstacle.
- Restart and saturation: with SCORE_MAX = 3, jump every lap → score saturates at 3. Force a collision, then press in OVER → running = 1, score = 0, obstacle_col = 15, game_over = 0.

Source files
------------

// File: rtl/dino_game_ctrl.sv
// dino_game_ctrl - game-logic stage of the dinosaur game.
//
// Takes the clock divider's slow square wave as a game-tick level, edge
// detects it in the clock_in domain, and runs the top game FSM
// (IDLE/RUN/OVER), the jump sub-FSM, the obstacle scroller, collision
// detection and the saturating score counter. All outputs are registered.
//
// Ports:
//   clock_in     system clock (same clock as the divider)
//   reset        synchronous, active-high reset
//   game_tick    divider clock_out level; each rising edge is one game tick
//   btn_jump     raw jump pushbutton, asynchronous, active-high
//   dino_h       dinosaur height, 0 = on the ground
//   obstacle_col current obstacle column
//   score        obstacles passed, saturating at SCORE_MAX
//   running      high while in RUN
//   game_over    high while in OVER
module dino_game_ctrl #(
  parameter int COLS       = 16,   // <= 16
  parameter int DINO_COL   = 2,    // < COLS
  parameter int JUMP_H     = 3,    // 1..3
  parameter int HANG_TICKS = 2,    // 0..255
  parameter int SCORE_MAX  = 9999
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic        game_tick,
  input  logic        btn_jump,
  output logic [1:0]  dino_h,
  output logic [3:0]  obstacle_col,
  output logic [13:0] score,
  output logic        running,
  output logic        game_over
);

  localparam logic [3:0]  COL_LAST  = 4'(COLS - 1);
  localparam logic [3:0]  DINO_C    = 4'(DINO_COL);
  localparam logic [1:0]  PEAK      = 2'(JUMP_H);
  localparam logic [7:0]  HANG_INIT = 8'(HANG_TICKS);
  localparam logic [13:0] SC_MAX    = 14'(SCORE_MAX);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
  typedef enum logic [1:0] {GROUND, UP, HANG, DOWN} jump_t;

  state_t     state;
  jump_t      jump;
  logic [7:0] hang_cnt;
  logic       jump_pending;
  logic       tick_q;
  logic       btn_s1, btn_s2, btn_q;

  logic       tick_p, press_p, collide;
  logic [1:0] h_inc;

  assign tick_p  = game_tick & ~tick_q;
  assign press_p = btn_s2 & ~btn_q;
  assign collide = (obstacle_col == DINO_C) && (dino_h == 2'd0);
  // Next height on an upward step; also 1 when launching from the ground.
  assign h_inc   = dino_h + 2'd1;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state        <= IDLE;
      jump         <= GROUND;
      hang_cnt     <= 8'd0;
      jump_pending <= 1'b0;
      tick_q       <= 1'b0;
      btn_s1       <= 1'b0;
      btn_s2       <= 1'b0;
      btn_q        <= 1'b0;
      dino_h       <= 2'd0;
      obstacle_col <= COL_LAST;
      score        <= 14'd0;
      running      <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      tick_q <= game_tick;
      btn_s1 <= btn_jump;
      btn_s2 <= btn_s1;
      btn_q  <= btn_s2;

      case (state)
        IDLE: begin
          // The starting press is consumed; it does not queue a jump.
          if (press_p) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end

        RUN: begin
          if (collide) begin
            // Collision wins over a coincident tick: positions freeze as-is.
            state     <= OVER;
            running   <= 1'b0;
            game_over <= 1'b1;
          end else begin
            if (tick_p) begin
              if (obstacle_col == 4'd0) begin
                obstacle_col <= COL_LAST;
                if (score < SC_MAX) score <= score + 14'd1;
              end else begin
                obstacle_col <= obstacle_col - 4'd1;
              end

              case (jump)
                GROUND, UP: begin
                  if (jump == UP || jump_pending) begin
                    dino_h       <= h_inc;
                    jump_pending <= 1'b0;
                    if (h_inc == PEAK) begin
                      jump     <= (HANG_TICKS == 0) ? DOWN : HANG;
                      hang_cnt <= HANG_INIT;
                    end else begin
                      jump <= UP;
                    end
                  end
                end
                HANG: begin
                  // Loaded with HANG_TICKS on arrival; last hang tick flips to DOWN.
                  if (hang_cnt <= 8'd1) jump <= DOWN;
                  else                  hang_cnt <= hang_cnt - 8'd1;
                end
                DOWN: begin
                  dino_h <= dino_h - 2'd1;
                  if (dino_h == 2'd1) jump <= GROUND;
                end
                default: jump <= GROUND;
              endcase
            end

            // The tick sees only the registered pending flag, so a press in
            // the same cycle is serviced next tick. A launch this cycle
            // clears the flag and swallows any coincident press.
            if (press_p && jump == GROUND && !(tick_p && jump_pending))
              jump_pending <= 1'b1;
          end
        end

        OVER: begin
          if (press_p) begin
            state        <= RUN;
            running      <= 1'b1;
            game_over    <= 1'b0;
            dino_h       <= 2'd0;
            obstacle_col <= COL_LAST;
            score        <= 14'd0;
            jump         <= GROUND;
            jump_pending <= 1'b0;
            hang_cnt     <= 8'd0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Testbench for dino_game_ctrl. Expected output vectors are pushed onto a
// scoreboard queue when stimulus is applied and popped when the outputs
// have settled. SCORE_MAX is reduced to 3 to reach saturation quickly.
module tb_dino_game_ctrl;

  logic        clock_in = 1'b0;
  logic        reset = 1'b0;
  logic        game_tick = 1'b0;
  logic        btn_jump = 1'b0;
  logic [1:0]  dino_h;
  logic [3:0]  obstacle_col;
  logic [13:0] score;
  logic        running, game_over;

  dino_game_ctrl #(
    .COLS(16), .DINO_COL(2), .JUMP_H(3), .HANG_TICKS(2), .SCORE_MAX(3)
  ) dut (
    .clock_in(clock_in), .reset(reset), .game_tick(game_tick), .btn_jump(btn_jump),
    .dino_h(dino_h), .obstacle_col(obstacle_col), .score(score),
    .running(running), .game_over(game_over)
  );

  always #5 clock_in = ~clock_in;

  // {h[1:0], col[3:0], score[13:0], running, game_over}
  logic [21:0] obs;
  assign obs = {dino_h, obstacle_col, score, running, game_over};

  logic [21:0] exp_q[$];
  logic [21:0] e;
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [21:0] pk(int h, int c, int s, bit r, bit o);
    return {2'(h), 4'(c), 14'(s), r, o};
  endfunction

  // Jump height profile for JUMP_H=3, HANG_TICKS=2, one entry per tick.
  int jh[8] = '{1, 2, 3, 3, 3, 2, 1, 0};

  task automatic do_tick();
    @(negedge clock_in) game_tick = 1'b1;
    @(negedge clock_in) game_tick = 1'b0;
    @(negedge clock_in);
    @(negedge clock_in);
  endtask

  // Press acts on the third posedge after the button rises.
  task automatic do_press();
    @(negedge clock_in) btn_jump = 1'b1;
    repeat (3) @(negedge clock_in);
    btn_jump = 1'b0;
    repeat (3) @(negedge clock_in);
  endtask

  task automatic do_reset();
    @(negedge clock_in) reset = 1'b1;
    repeat (2) @(negedge clock_in);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    exp_q.push_back(pk(0, 15, 0, 0, 0));
    e = exp_q.pop_front(); n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", obs, e);
    end
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(pk(0, 15, 0, 0, 0));
      do_tick();
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL idle_tick%0d: got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_collision();
    exp_q.push_back(pk(0, 15, 0, 1, 0));
    do_press();
    e = exp_q.pop_front(); n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL start: got %h want %h", obs, e);
    end
    for (int c = 14; c >= 3; c--) begin
      exp_q.push_back(pk(0, c, 0, 1, 0));
      do_tick();
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL scroll_col%0d: got %h want %h", c, obs, e);
      end
    end
    // Tick into the dinosaur's column: game_over follows one cycle later.
    exp_q.push_back(pk(0, 2, 0, 1, 0));
    exp_q.push_back(pk(0, 2, 0, 0, 1));
    @(negedge clock_in) game_tick = 1'b1;
    @(negedge clock_in) game_tick = 1'b0;
    e = exp_q.pop_front(); n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL hit_cycle0: got %h want %h", obs, e);
    end
    @(negedge clock_in);
    e = exp_q.pop_front(); n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL hit_cycle1: got %h want %h", obs, e);
    end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(pk(0, 2, 0, 0, 1));
      do_tick();
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL over_frozen%0d: got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_clear_jump();
    int cc[8] = '{3, 2, 1, 0, 15, 14, 13, 12};
    int cs[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    do_reset();
    do_press();
    for (int i = 0; i < 11; i++) do_tick();
    exp_q.push_back(pk(0, 4, 0, 1, 0));
    do_press();
    e = exp_q.pop_front(); n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL clear_pre: got %h want %h", obs, e);
    end
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(pk(jh[i], cc[i], cs[i], 1, 0));
      do_tick();
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL clear_step%0d: got %h want %h", i, obs, e);
      end
    end
  endtask

  // Continues from (col 12, h 0, score 1).
  task automatic test_reset_mid_jump();
    do_press();
    do_tick();
    exp_q.push_back(pk(2, 10, 1, 1, 0));
    do_tick();
    e = exp_q.pop_front(); n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL mid_pre: got %h want %h", obs, e);
    end
    exp_q.push_back(pk(0, 15, 0, 0, 0));
    @(negedge clock_in) reset = 1'b1;
    @(negedge clock_in) reset = 1'b0;
    e = exp_q.pop_front(); n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL mid_reset: got %h want %h", obs, e);
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pk(0, 15, 0, 0, 0));
      do_tick();
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL mid_idle%0d: got %h want %h", i, obs, e);
      end
    end
  endtask

  // Actions: 0 tick, 1 press then tick, 2 press in the tick's cycle,
  // 3 press and keep holding, then tick.
  task automatic test_press_rules();
    int pa[27] = '{1,0,1,0,0,0,0,0,0, 2,0,0,0,0,0,0,0,0, 3,0,0,0,0,0,0,0,0};
    int pc[27] = '{14,13,12,11,10,9,8,7,6, 5,4,3,2,1,0,15,14,13,
                   12,11,10,9,8,7,6,5,4};
    int ph[27] = '{1,2,3,3,3,2,1,0,0, 0,1,2,3,3,3,2,1,0,
                   1,2,3,3,3,2,1,0,0};
    int ps[27] = '{0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,1,1,
                   1,1,1,1,1,1,1,1,1};
    do_reset();
    do_press();
    for (int i = 0; i < 27; i++) begin
      exp_q.push_back(pk(ph[i], pc[i], ps[i], 1, 0));
      case (pa[i])
        1: begin do_press(); do_tick(); end
        2: begin
          @(negedge clock_in) btn_jump = 1'b1;
          repeat (2) @(negedge clock_in);
          game_tick = 1'b1;
          @(negedge clock_in) game_tick = 1'b0;
          btn_jump = 1'b0;
          repeat (2) @(negedge clock_in);
        end
        3: begin
          @(negedge clock_in) btn_jump = 1'b1;
          repeat (3) @(negedge clock_in);
          do_tick();
        end
        default: do_tick();
      endcase
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL press_step%0d: got %h want %h", i, obs, e);
      end
    end
    btn_jump = 1'b0;
    repeat (3) @(negedge clock_in);
  endtask

  task automatic test_restart_sat();
    int m_col = 15;
    int m_sc = 0;
    do_reset();
    do_press();
    for (int lap = 0; lap < 5; lap++) begin
      for (int k = 0; k < 20 && m_col != 4; k++) begin
        m_col--;
        exp_q.push_back(pk(0, m_col, m_sc, 1, 0));
        do_tick();
        e = exp_q.pop_front(); n_vec++;
        if (obs !== e) begin
          n_err++;
          $display("FAIL lap%0d_scroll: got %h want %h", lap, obs, e);
        end
      end
      do_press();
      for (int k = 0; k < 8; k++) begin
        if (m_col == 0) begin
          m_col = 15;
          if (m_sc < 3) m_sc++;
        end else m_col--;
        exp_q.push_back(pk(jh[k], m_col, m_sc, 1, 0));
        do_tick();
        e = exp_q.pop_front(); n_vec++;
        if (obs !== e) begin
          n_err++;
          $display("FAIL lap%0d_jump%0d: got %h want %h", lap, k, obs, e);
        end
      end
    end
    // From column 12 run into the dinosaur; game_over is up by the end of
    // the tenth tick.
    for (int k = 0; k < 10; k++) begin
      m_col--;
      exp_q.push_back(pk(0, m_col, 3, k < 9, k == 9));
      do_tick();
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL sat_crash%0d: got %h want %h", k, obs, e);
      end
    end
    exp_q.push_back(pk(0, 15, 0, 1, 0));
    do_press();
    e = exp_q.pop_front(); n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL restart: got %h want %h", obs, e);
    end
    exp_q.push_back(pk(0, 14, 0, 1, 0));
    do_tick();
    e = exp_q.pop_front(); n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL restart_tick: got %h want %h", obs, e);
    end
  endtask

  initial begin
    test_reset();
    test_collision();
    test_clear_jump();
    test_reset_mid_jump();
    test_press_rules();
    test_restart_sat();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
